// File: rtl/score_regfile_if.sv
// Score update / score read bus between game logic, the score-drawing stage and score_regfile.
interface score_regfile_if #(
   parameter int SCORE_W = 32
);
   logic               add_en;
   logic               add_sub;
   logic [3:0]         add_player;
   logic [15:0]        add_pts;
   logic               add_ready;
   logic               score_re;
   logic [3:0]         score_addr;
   logic [SCORE_W-1:0] score_data;
   logic               score_valid_data;

   modport master (
      output add_en, add_sub, add_player, add_pts, score_re, score_addr,
      input  add_ready, score_data, score_valid_data
   );

   modport slave (
      input  add_en, add_sub, add_player, add_pts, score_re, score_addr,
      output add_ready, score_data, score_valid_data
   );
endinterface

// File: rtl/score_regfile.sv
// Per-player saturating score store with dirty flags, 1-cycle reads and a
// one-entry-per-cycle clear-all sweep.
module score_regfile #(
   parameter int                 NUM_PLAYERS = 8,
   parameter int                 SCORE_W     = 32,
   parameter logic [SCORE_W-1:0] MAX_SCORE   = 999999
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr_all,
   score_regfile_if.slave         bus,
   output logic [NUM_PLAYERS-1:0] dirty,
   output logic                   any_dirty,
   output logic                   busy
);
   localparam int AW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

   typedef enum logic {S_IDLE, S_SWEEP} state_t;

   state_t                 r_state, w_next;
   logic [AW-1:0]          r_idx;
   logic [SCORE_W-1:0]     r_score [NUM_PLAYERS];
   logic [NUM_PLAYERS-1:0] r_dirty;
   logic [SCORE_W-1:0]     r_data;
   logic                   r_valid;
   logic                   r_pend;

   logic                   w_idle;
   logic                   w_add_hit, w_rd_hit, w_upd;
   logic [AW-1:0]          w_add_idx, w_rd_idx;
   logic [SCORE_W-1:0]     w_cur, w_pts, w_new;
   logic [SCORE_W:0]       w_sum;

   assign w_idle    = (r_state == S_IDLE);
   assign w_add_hit = (32'(bus.add_player) < NUM_PLAYERS);
   assign w_rd_hit  = (32'(bus.score_addr) < NUM_PLAYERS);
   assign w_add_idx = bus.add_player[AW-1:0];
   assign w_rd_idx  = bus.score_addr[AW-1:0];
   assign w_cur     = r_score[w_add_idx];
   assign w_pts     = {{(SCORE_W-16){1'b0}}, bus.add_pts};
   // One extra bit on the sum so a large add can never wrap before the clamp.
   assign w_sum     = {1'b0, w_cur} + {1'b0, w_pts};
   assign w_new     = bus.add_sub ? ((w_pts > w_cur) ? '0 : (w_cur - w_pts))
                                  : ((w_sum > {1'b0, MAX_SCORE}) ? MAX_SCORE : w_sum[SCORE_W-1:0]);
   // clr_all wins over a same-cycle update.
   assign w_upd     = w_idle && !clr_all && bus.add_en && w_add_hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (clr_all) w_next = S_SWEEP;
         S_SWEEP: if (r_idx == AW'(NUM_PLAYERS-1)) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_PLAYERS; i++) r_score[i] <= '0;
         r_dirty <= '1;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_pend  <= 1'b0;
         r_idx   <= '0;
      end else begin
         r_valid <= 1'b0;
         if (w_idle) begin
            if (clr_all) r_idx <= '0;
            // A read parked during the sweep is answered first; it sees cleared data.
            if (r_pend) begin
               r_valid <= 1'b1;
               r_data  <= '0;
               r_pend  <= 1'b0;
            end else if (bus.score_re) begin
               r_valid <= 1'b1;
               r_data  <= w_rd_hit ? r_score[w_rd_idx] : '0;
               if (w_rd_hit) r_dirty[w_rd_idx] <= 1'b0;
            end
            if (w_upd) begin
               r_score[w_add_idx] <= w_new;
               r_dirty[w_add_idx] <= 1'b1;
            end
         end else begin
            r_score[r_idx] <= '0;
            r_dirty[r_idx] <= 1'b1;
            r_idx          <= r_idx + AW'(1);
            if (bus.score_re) r_pend <= 1'b1;
         end
      end
   end

   assign bus.add_ready        = w_idle;
   assign bus.score_data       = r_data;
   assign bus.score_valid_data = r_valid;
   assign dirty                = r_dirty;
   assign any_dirty            = |r_dirty;
   assign busy                 = !w_idle;
endmodule

// File: tb/tb_score_regfile.sv
// Randomized + directed bench for score_regfile: a scoreboard queue of expected
// read responses is filled by a behavioural model and drained by a monitor.
module tb_score_regfile;
   localparam int  NP  = 8;
   localparam int  SW  = 32;
   localparam longint MAXS = 999999;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          clr_all = 1'b0;
   logic [NP-1:0] dirty;
   logic          any_dirty, busy;

   score_regfile_if #(.SCORE_W(SW)) bus ();

   score_regfile #(.NUM_PLAYERS(NP), .SCORE_W(SW), .MAX_SCORE(32'(MAXS))) dut (
      .clk(clk), .rst(rst), .clr_all(clr_all), .bus(bus.slave),
      .dirty(dirty), .any_dirty(any_dirty), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct { longint data; int due; } exp_t;
   exp_t sb[$];

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", n, act, exp, $time);
      end
   endtask

   // Reference model: plain arithmetic on an array of scores
   longint    m_score [NP];
   bit [NP-1:0] m_dirty;
   int        m_left;
   bit        m_pend;

   task automatic model_reset();
      for (int i = 0; i < NP; i++) m_score[i] = 0;
      m_dirty = '1;
      m_left  = 0;
      m_pend  = 0;
      sb.delete();
   endtask

   task automatic push(input longint d);
      exp_t e;
      e.data = d;
      e.due  = cyc + 1;
      sb.push_back(e);
   endtask

   task automatic model(input bit clr, en, sub, input int pl, input longint pts,
                        input bit re, input int addr);
      if (m_left > 0) begin
         if (re) m_pend = 1;
         m_left--;
      end else begin
         if (m_pend) begin
            push(0);
            m_pend = 0;
         end else if (re) begin
            push(addr < NP ? m_score[addr] : 0);
            if (addr < NP) m_dirty[addr] = 0;
         end
         if (clr) begin
            m_left = NP;
            for (int i = 0; i < NP; i++) m_score[i] = 0;
            m_dirty = '1;
         end else if (en && pl < NP) begin
            if (sub) m_score[pl] = (pts > m_score[pl]) ? 0 : m_score[pl] - pts;
            else     m_score[pl] = (m_score[pl] + pts > MAXS) ? MAXS : m_score[pl] + pts;
            m_dirty[pl] = 1;
         end
      end
   endtask

   // Monitor: every valid must match the head of the scoreboard on its due cycle
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.score_valid_data) begin
            if (sb.size() == 0) chk("spurious_valid", 1, 0);
            else begin
               exp_t e;
               e = sb.pop_front();
               chk("rd_latency", 64'(cyc), 64'(e.due));
               chk("rd_data", 64'(bus.score_data), 64'(e.data));
            end
         end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            void'(sb.pop_front());
            chk("rd_missing_valid", 0, 1);
         end
      end
   end

   task automatic step(input bit clr, en, sub, input int pl, input int pts,
                       input bit re, input int addr);
      clr_all        = clr;
      bus.add_en     = en;
      bus.add_sub    = sub;
      bus.add_player = 4'(pl);
      bus.add_pts    = 16'(pts);
      bus.score_re   = re;
      bus.score_addr = 4'(addr);
      @(posedge clk);
      model(clr, en, sub, pl, longint'(pts), re, addr);
      #1;
      clr_all = 0; bus.add_en = 0; bus.score_re = 0;
      @(negedge clk);
      chk("busy", 64'(busy), 64'(m_left > 0));
      chk("add_ready", 64'(bus.add_ready), 64'(m_left == 0));
      if (m_left == 0) begin
         chk("dirty", 64'(dirty), 64'(m_dirty));
         chk("any_dirty", 64'(any_dirty), 64'(|m_dirty));
      end
   endtask

   task automatic upd(input bit sub, input int pl, input int pts);
      step(0, 1, sub, pl, pts, 0, 0);
   endtask
   task automatic rd(input int addr);
      step(0, 0, 0, 0, 0, 1, addr);
   endtask
   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic reset_checks();
      chk("rst_valid", 64'(bus.score_valid_data), 0);
      chk("rst_data", 64'(bus.score_data), 0);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_ready", 64'(bus.add_ready), 1);
      chk("rst_dirty", 64'(dirty), 64'(8'hFF));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.add_en = 0; bus.add_sub = 0; bus.add_player = 0; bus.add_pts = 0;
      bus.score_re = 0; bus.score_addr = 0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 0;
      reset_checks();

      // Adds then saturating-low subtract
      upd(0, 2, 500);  rd(2);
      upd(0, 2, 500);  rd(2);
      upd(1, 2, 1200); rd(2);

      // Saturating high, then add 0 still marks dirty
      for (int i = 0; i < 15; i++) upd(0, 5, 65535);
      upd(0, 5, 16965); rd(5);
      upd(0, 5, 100);   rd(5);
      upd(0, 5, 0);     rd(5);

      // Same-cycle read and update of one player
      upd(0, 1, 10); rd(1);
      step(0, 1, 0, 1, 7, 1, 1);
      rd(1);

      // clr_all beats a same-cycle update; a read parked mid-sweep
      upd(0, 0, 100);
      step(1, 1, 0, 0, 55, 0, 0);
      idle(); idle();
      rd(4);
      repeat (8) idle();
      rd(0); rd(2);

      // Reset in the middle of a sweep with a parked read
      step(1, 0, 0, 0, 0, 0, 0);
      idle(); rd(6);
      #2 rst = 1;
      #1;
      chk("rst_async_busy", 64'(busy), 0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 0;
      reset_checks();
      rd(3);

      // Full address range including unimplemented entries
      upd(0, 7, 42); upd(0, 6, 1);
      for (int a = 0; a < 16; a++) rd(a);
      for (int a = 8; a < 16; a++) upd(0, a, 9);

      // Randomized traffic
      for (int n = 0; n < 500; n++) begin
         bit clr, en, sub, re;
         int pl, pts, addr;
         clr  = ($urandom_range(0, 39) == 0);
         en   = $urandom_range(0, 1);
         sub  = ($urandom_range(0, 3) == 0);
         pl   = $urandom_range(0, 9);
         pts  = ($urandom_range(0, 2) == 0) ? 65535 : int'($urandom_range(0, 65535));
         re   = ($urandom_range(0, 4) < 2);
         addr = $urandom_range(0, 9);
         step(clr, en, sub, pl, pts, re, addr);
      end
      repeat (12) idle();
      chk("sb_drained", 64'(sb.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/score_regfile.md
Name: score_regfile

Overview:
- Per-player score store that sits directly upstream of the score-drawing stage and serves its score_re/score_addr read requests with score_data/score_valid_data.
- Game logic adds or subtracts points per player, with saturating arithmetic.
- Supports a multi-cycle clear-all sweep, modelled as a RAM-style reset.
- Per-player dirty flags let the frame controller decide when the score overlay needs a redraw.

Parameters:
- NUM_PLAYERS, 8: number of implemented score entries; addresses 0..NUM_PLAYERS-1.
- SCORE_W, 32: width of each stored score and of score_data.
- MAX_SCORE, 999999: saturation ceiling; must be < 2^SCORE_W.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr_all  in  1  one-cycle pulse; starts the clear-all sweep.
- add_en  in  1  point-update strobe, sampled when add_ready=1.
- add_sub  in  1  0 = add, 1 = subtract.
- add_player  in  4  player index for the update.
- add_pts  in  16  point magnitude, zero-extended to SCORE_W.
- add_ready  out  1  high when updates are accepted (not sweeping).
- score_re  in  1  read request strobe.
- score_addr  in  4  player index to read.
- score_data  out  SCORE_W  read data.
- score_valid_data  out  1  one-cycle pulse qualifying score_data.
- dirty  out  NUM_PLAYERS  per-player changed-since-last-read flags.
- any_dirty  out  1  OR of dirty.
- busy  out  1  clear sweep in progress.

Behaviour:
- **Reset (rst=1, any time, including mid-sweep or mid-read):**
  - All scores 0; dirty all ones.
  - score_data 0; score_valid_data 0; busy 0; add_ready 1; pending-read flag 0.
  - FSM returns to IDLE.
- **FSM states: IDLE, SWEEP.**
  - IDLE→SWEEP when clr_all=1. Sweep index is set to 0; busy=1 and add_ready=0 from the next cycle.
  - In SWEEP, one entry per cycle: score[idx]←0 and dirty[idx]←1, then idx increments.
  - After entry NUM_PLAYERS-1 is written, the next state is IDLE. busy is therefore high for exactly NUM_PLAYERS cycles.
  - clr_all while in SWEEP is ignored (the sweep does not restart).
- **Updates (IDLE only, add_en=1):**
  - add_player ≥ NUM_PLAYERS: ignored, no flag change.
  - Add: new = min(score + pts, MAX_SCORE).
  - Subtract: new = (pts > score) ? 0 : score − pts.
  - Compute the sum in SCORE_W+1 bits; no wrap-around is permitted.
  - The result is written at the clock edge and dirty[player] is set. This holds even when the value is unchanged (saturated or pts=0).
  - add_en while add_ready=0 is dropped.
  - clr_all and add_en in the same IDLE cycle: clr_all wins and the update is dropped.
- **Reads:**
  - score_re sampled in IDLE → score_valid_data=1 on the next cycle with score_data = stored value at the time of sampling. Latency is 1.
  - Read and update to the same player in the same cycle: the read returns the pre-update value. dirty ends set, because the update has priority over the clear.
  - A read clears dirty[addr] at the same edge it is sampled, unless an update to that player occurs in the same cycle.
  - score_addr ≥ NUM_PLAYERS: returns 0 with valid, no dirty change.
  - score_re during SWEEP: the request and address are captured into a single pending slot; a later re during the same sweep overwrites the slot.
  - A pending read is served on the first IDLE cycle after the sweep and returns 0, with valid one cycle after that.
  - Only one outstanding read; valid is never asserted for two consecutive cycles from a single request.
- **Outputs:**
  - score_data holds its last value when valid=0.
  - score_valid_data is registered; the remaining outputs are combinational from registers.

Test Plan:
1. rst pulse mid-operation → the following cycle score_valid_data=0, busy=0, dirty=8'hFF; reading player 3 returns 0 with valid exactly 1 cycle after re, and dirty[3] clears.
2. Add 500 to player 2 twice, then subtract 1200 → reads return 500, 1000, then 0 (saturated low); dirty[2] is set after each update.
3. Player 5 set to 999990, add 100 → reads 999999; add 0 → still 999999 and dirty[5] set.
4. Same-cycle add 7 to player 1 with a read of player 1 (prior value 10) → read returns 10, dirty[1]=1, next read returns 17.
5. clr_all with add_en in the same cycle → update dropped; busy high exactly 8 cycles; a read issued during the sweep returns 0 with valid 1 cycle after busy falls; all dirty bits set.
6. Sequential reads of addresses 0..15 → valid on each with a 1-cycle lag; addresses 8..15 return 0 and dirty bits 8+ are unaffected.
